// File: rtl/prco_run_ctrl_pkg.sv
// Shared types for the prco run controller: FSM state encoding and core control bundle.
// No logic; types and a helper that maps a state to the core control levels.
// Consumers: prco_run_ctrl and any monitor that decodes q_state.
package prco_run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_STALL = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   // Levels broadcast to every core
   typedef struct packed {
      logic en;
      logic reset;
      logic stalled;
   } core_ctl_t;

   localparam core_ctl_t CTL_IDLE = '{en: 1'b0, reset: 1'b1, stalled: 1'b1};

   // Core control levels for a given state; RUN stall follows the request
   function automatic core_ctl_t ctl_for(input state_t st, input logic stall_req);
      core_ctl_t c;
      c = CTL_IDLE;
      case (st)
         ST_IDLE:  c = CTL_IDLE;
         ST_RESET: c = '{en: 1'b1, reset: 1'b1, stalled: 1'b1};
         ST_STALL: c = '{en: 1'b1, reset: 1'b0, stalled: 1'b1};
         ST_RUN:   c = '{en: 1'b1, reset: 1'b0, stalled: stall_req};
         default:  c = CTL_IDLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/prco_trace_fifo.sv
// Show-ahead trace FIFO with register-array storage and wrap-bit pointers.
// Latency: a write is visible at the head the cycle after the writing edge.
// Backpressure: write accepted when not full or when a pop happens on the same edge.
module prco_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_clr,
   input  logic                     i_wr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_rd,
   output logic                     q_valid,
   output logic [WIDTH-1:0]         q_data,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     q_full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             empty;
   logic             full;
   logic             do_rd;
   logic             do_wr;

   // Occupancy flags and accepted operations; a pop on an empty FIFO is ignored
   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      do_rd = i_rd && !empty;
      do_wr = i_wr && (!full || do_rd);
   end

   // Pointer update; clear empties the FIFO without touching storage
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (i_clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility
   always_ff @(posedge i_clk) begin
      if (do_wr && !i_clr) mem[wr_ptr[AW-1:0]] <= i_wdata;
   end

   // Head presentation, forced to zero while empty so stale entries never leak
   always_comb begin
      q_valid = !empty;
      q_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
      q_count = wr_ptr - rd_ptr;
      q_full  = full;
   end

endmodule

// File: rtl/prco_run_ctrl.sv
// Run controller: sequences core enable/reset/stall bring-up, then traces the selected core's debug bus.
// Latency: state/control outputs change the cycle after the deciding edge; captures visible one cycle later.
// Backpressure: none on cores; captures arriving while the trace FIFO is full are dropped and flagged.
module prco_run_ctrl
   import prco_run_ctrl_pkg::*;
#(
   parameter int NUM_CORES    = 1,
   parameter int DEBUG_W      = 8,
   parameter int RESET_CYCLES = 1,
   parameter int STALL_CYCLES = 2,
   parameter int TRACE_DEPTH  = 16,
   localparam int SEL_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
   localparam int CNT_W       = $clog2(TRACE_DEPTH) + 1
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_start,
   input  logic                         i_halt,
   input  logic                         i_stall_req,
   input  logic [SEL_W-1:0]             i_trace_sel,
   input  logic [NUM_CORES*DEBUG_W-1:0] i_debug,
   input  logic [NUM_CORES-1:0]         i_debug_instr_clk,
   input  logic                         i_trace_rd,
   output logic                         q_core_en,
   output logic                         q_core_reset,
   output logic                         q_core_stalled,
   output logic [1:0]                   q_state,
   output logic                         q_trace_valid,
   output logic [DEBUG_W-1:0]           q_trace_data,
   output logic [CNT_W-1:0]             q_trace_count,
   output logic                         q_trace_overflow
);

   localparam int MAX_CYC = (RESET_CYCLES > STALL_CYCLES) ? RESET_CYCLES : STALL_CYCLES;
   localparam int PH_W    = $clog2(MAX_CYC) + 1;
   localparam logic [PH_W-1:0] RESET_LOAD = PH_W'(RESET_CYCLES - 1);
   localparam logic [PH_W-1:0] STALL_LOAD = PH_W'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
   localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);

   state_t             state;
   state_t             state_nxt;
   logic [PH_W-1:0]    phase;
   logic [PH_W-1:0]    phase_nxt;
   core_ctl_t          ctl;
   core_ctl_t          ctl_nxt;
   logic               trace_clk_now;
   logic               trace_clk_prev;
   logic [DEBUG_W-1:0] trace_slice;
   logic               capture;
   logic               fifo_clr;
   logic               fifo_full;
   logic               overflow;

   // State register, phase counter and registered core controls
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_IDLE;
         phase <= '0;
         ctl   <= CTL_IDLE;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
         ctl   <= ctl_nxt;
      end
   end

   // Next state: halt beats both start and timer expiry; phase reloads on every entry
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      case (state)
         ST_IDLE: begin
            if (i_start && !i_halt) begin
               state_nxt = ST_RESET;
               phase_nxt = RESET_LOAD;
            end
         end
         ST_RESET: begin
            if (i_halt) begin
               state_nxt = ST_IDLE;
               phase_nxt = '0;
            end else if (phase == '0) begin
               if (STALL_CYCLES == 0) begin
                  state_nxt = ST_RUN;
                  phase_nxt = '0;
               end else begin
                  state_nxt = ST_STALL;
                  phase_nxt = STALL_LOAD;
               end
            end else begin
               phase_nxt = phase - PH_ONE;
            end
         end
         ST_STALL: begin
            if (i_halt) begin
               state_nxt = ST_IDLE;
               phase_nxt = '0;
            end else if (phase == '0) begin
               state_nxt = ST_RUN;
               phase_nxt = '0;
            end else begin
               phase_nxt = phase - PH_ONE;
            end
         end
         ST_RUN: begin
            if (i_halt) begin
               state_nxt = ST_IDLE;
               phase_nxt = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
         end
      endcase
   end

   // Outputs: control levels for the state being entered, so they line up with q_state
   always_comb begin
      ctl_nxt  = ctl_for(state_nxt, i_stall_req);
      fifo_clr = (state == ST_IDLE) && i_start && !i_halt;
   end

   // Select the traced core's instr clock and debug slice
   always_comb begin
      trace_clk_now = 1'b0;
      trace_slice   = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (i_trace_sel == SEL_W'(k)) begin
            trace_clk_now = i_debug_instr_clk[k];
            trace_slice   = i_debug[k*DEBUG_W +: DEBUG_W];
         end
      end
      capture = (state == ST_RUN) && !trace_clk_prev && trace_clk_now;
   end

   // Previous instr clock level of the selected core, tracked in every state
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) trace_clk_prev <= 1'b0;
      else            trace_clk_prev <= trace_clk_now;
   end

   // Sticky overflow: set when a capture is lost, cleared only by a fresh start
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)                            overflow <= 1'b0;
      else if (fifo_clr)                         overflow <= 1'b0;
      else if (capture && fifo_full && !i_trace_rd) overflow <= 1'b1;
   end

   prco_trace_fifo #(
      .WIDTH (DEBUG_W),
      .DEPTH (TRACE_DEPTH)
   ) u_trace_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (fifo_clr),
      .i_wr      (capture),
      .i_wdata   (trace_slice),
      .i_rd      (i_trace_rd),
      .q_valid   (q_trace_valid),
      .q_data    (q_trace_data),
      .q_count   (q_trace_count),
      .q_full    (fifo_full)
   );

   assign q_core_en        = ctl.en;
   assign q_core_reset     = ctl.reset;
   assign q_core_stalled   = ctl.stalled;
   assign q_state          = state;
   assign q_trace_overflow = overflow;

endmodule

// File: tb/tb_prco_run_ctrl.sv
// Self-checking bench for prco_run_ctrl with two cores and a 4-entry trace FIFO.
// Control outputs are checked against hand-computed constants; trace pops go through a scoreboard queue.
module tb_prco_run_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        halt;
   logic        stall_req;
   logic [0:0]  trace_sel;
   logic [15:0] debug;
   logic [1:0]  instr_clk;
   logic        trace_rd;
   logic        core_en;
   logic        core_reset;
   logic        core_stalled;
   logic [1:0]  state;
   logic        trace_valid;
   logic [7:0]  trace_data;
   logic [2:0]  trace_count;
   logic        trace_overflow;

   int          compared;
   int          mismatched;
   logic [7:0]  expq [$];
   logic [7:0]  mon_exp;

   prco_run_ctrl #(
      .NUM_CORES    (2),
      .DEBUG_W      (8),
      .RESET_CYCLES (1),
      .STALL_CYCLES (2),
      .TRACE_DEPTH  (4)
   ) dut (
      .i_clk             (clk),
      .i_reset_n         (rst_n),
      .i_start           (start),
      .i_halt            (halt),
      .i_stall_req       (stall_req),
      .i_trace_sel       (trace_sel),
      .i_debug           (debug),
      .i_debug_instr_clk (instr_clk),
      .i_trace_rd        (trace_rd),
      .q_core_en         (core_en),
      .q_core_reset      (core_reset),
      .q_core_stalled    (core_stalled),
      .q_state           (state),
      .q_trace_valid     (trace_valid),
      .q_trace_data      (trace_data),
      .q_trace_count     (trace_count),
      .q_trace_overflow  (trace_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},    state, 0);
      chk({tag, "_en"},       core_en, 0);
      chk({tag, "_reset"},    core_reset, 1);
      chk({tag, "_stalled"},  core_stalled, 1);
      chk({tag, "_valid"},    trace_valid, 0);
      chk({tag, "_count"},    trace_count, 0);
      chk({tag, "_overflow"}, trace_overflow, 0);
      chk({tag, "_data"},     trace_data, 0);
   endtask

   // One low-then-high instr clock pulse on a core, presenting d with the rising edge
   task automatic pulse(input int core, input logic [7:0] d, input bit expect_cap);
      instr_clk[core] = 1'b0;
      step();
      debug[core*8 +: 8] = d;
      instr_clk[core] = 1'b1;
      if (expect_cap) expq.push_back(d);
      step();
      instr_clk[core] = 1'b0;
   endtask

   // Scoreboard monitor: every pop the bench requests is checked against the queue head
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && trace_rd && trace_valid) begin
            compared++;
            if (expq.size() == 0) begin
               mismatched++;
               $display("FAIL trace_pop: got %h, scoreboard empty", trace_data);
            end else begin
               mon_exp = expq.pop_front();
               if (trace_data !== mon_exp) begin
                  mismatched++;
                  $display("FAIL trace_pop: got %h, expected %h", trace_data, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      halt       = 1'b0;
      stall_req  = 1'b0;
      trace_sel  = 1'b0;
      debug      = '0;
      instr_clk  = '0;
      trace_rd   = 1'b0;
      repeat (3) step();
      chk_reset_vals("por");

      // Bring-up sequence with default timing
      rst_n = 1'b1;
      step();
      step();
      chk("idle_state", state, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rst_state", state, 1);
      chk("rst_en", core_en, 1);
      chk("rst_reset", core_reset, 1);
      chk("rst_stalled", core_stalled, 1);
      step();
      chk("stall1_state", state, 2);
      chk("stall1_reset", core_reset, 0);
      chk("stall1_stalled", core_stalled, 1);
      step();
      chk("stall2_state", state, 2);
      chk("stall2_stalled", core_stalled, 1);
      step();
      chk("run_state", state, 3);
      chk("run_en", core_en, 1);
      chk("run_reset", core_reset, 0);
      chk("run_stalled", core_stalled, 0);

      // Stall request in RUN, one cycle of latency
      stall_req = 1'b1;
      step();
      chk("stallreq_on", core_stalled, 1);
      stall_req = 1'b0;
      step();
      chk("stallreq_off", core_stalled, 0);

      // Two captures then drain
      pulse(0, 8'hA1, 1);
      pulse(0, 8'hB2, 1);
      chk("cap2_count", trace_count, 2);
      chk("cap2_head", trace_data, 8'hA1);
      trace_rd = 1'b1;
      step();
      trace_rd = 1'b0;
      chk("cap2_head_after_rd", trace_data, 8'hB2);
      chk("cap2_count_after_rd", trace_count, 1);
      trace_rd = 1'b1;
      step();
      trace_rd = 1'b0;
      chk("cap2_valid_empty", trace_valid, 0);
      chk("cap2_count_empty", trace_count, 0);

      // Fill past depth: fifth capture dropped, overflow sticks
      pulse(0, 8'h11, 1);
      pulse(0, 8'h22, 1);
      pulse(0, 8'h33, 1);
      pulse(0, 8'h44, 1);
      pulse(0, 8'h55, 0);
      chk("full_count", trace_count, 4);
      chk("full_overflow", trace_overflow, 1);
      chk("full_head", trace_data, 8'h11);
      // Pop and capture on the same edge while full
      instr_clk[0] = 1'b0;
      step();
      debug[7:0]   = 8'h66;
      instr_clk[0] = 1'b1;
      trace_rd     = 1'b1;
      expq.push_back(8'h66);
      step();
      trace_rd     = 1'b0;
      instr_clk[0] = 1'b0;
      chk("full_rdwr_count", trace_count, 4);
      chk("full_rdwr_head", trace_data, 8'h22);
      trace_rd = 1'b1;
      repeat (4) step();
      trace_rd = 1'b0;
      chk("drain_valid", trace_valid, 0);

      // Halt mid-run keeps contents; start outside IDLE is ignored
      pulse(0, 8'h77, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_in_run", state, 3);
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("halt_state", state, 0);
      chk("halt_en", core_en, 0);
      chk("halt_reset", core_reset, 1);
      chk("halt_stalled", core_stalled, 1);
      chk("halt_keep_count", trace_count, 1);
      chk("halt_keep_data", trace_data, 8'h77);
      chk("halt_keep_overflow", trace_overflow, 1);
      pulse(0, 8'h88, 0);
      chk("idle_no_capture", trace_count, 1);
      start = 1'b1;
      halt  = 1'b1;
      step();
      start = 1'b0;
      halt  = 1'b0;
      chk("start_halt_idle", state, 0);

      // Start clears FIFO and overflow; edges during RESET/STALL are not captured
      start = 1'b1;
      step();
      start = 1'b0;
      expq.delete();
      chk("restart_state", state, 1);
      chk("restart_count", trace_count, 0);
      chk("restart_valid", trace_valid, 0);
      chk("restart_overflow", trace_overflow, 0);
      debug[7:0]   = 8'h99;
      instr_clk[0] = 1'b1;
      step();
      instr_clk[0] = 1'b0;
      chk("bringup_no_capture", trace_count, 0);
      chk("restart_stall1", state, 2);
      step();
      chk("restart_stall2", state, 2);
      // Halt on the cycle the stall timer expires
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("halt_stall_state", state, 0);
      chk("halt_stall_en", core_en, 0);
      chk("halt_stall_reset", core_reset, 1);

      // Trace core 1; edges on core 0 are ignored
      trace_sel = 1'b1;
      instr_clk = '0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      chk("sel1_run", state, 3);
      pulse(0, 8'hE1, 0);
      pulse(0, 8'hE2, 0);
      chk("sel1_core0_ignored", trace_count, 0);
      pulse(1, 8'h5C, 1);
      chk("sel1_data", trace_data, 8'h5C);
      chk("sel1_count", trace_count, 1);
      pulse(1, 8'h6D, 1);
      pulse(1, 8'h7E, 1);
      pulse(1, 8'h48, 1);
      trace_rd = 1'b1;
      step();
      trace_rd = 1'b0;
      chk("sel1_count3", trace_count, 3);
      chk("sel1_head", trace_data, 8'h6D);

      // Async reset mid-run clears everything before any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      expq.delete();
      chk_reset_vals("async");
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_state", state, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
